// File: rtl/issue_scoreboard.sv
// Issue controller between decode and execute: busy-bit scoreboard for RAW/WAW stalls,
// an outstanding-write limit, and an issue hold after control transfers until branch resolution.
module issue_scoreboard #(
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [6:0]       dec_opcode,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    output logic             dec_ready,
    output logic             iss_valid,
    input  logic             iss_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             br_done,
    output logic             stall,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             spur_wb
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_BRWAIT = 1'b1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             state_q, state_d;
    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spur_q, spur_d;

    logic [31:0] wb_mask, eff;
    logic        full, hazard, is_ctrl, issue_wr, wb_nz, wb_hit, wb_spur;

    // A same-cycle writeback masks its register out of the hazard check (zero-bubble retire).
    always_comb begin
        wb_mask   = {31'b0, wb_valid} << wb_rd;
        eff       = busy_q & ~wb_mask;
        full      = (cnt_q == CNT_W'(MAX_PEND));
        hazard    = eff[dec_rs1] | eff[dec_rs2] | ((dec_rd != 5'd0) & (eff[dec_rd] | full));
        iss_valid = dec_valid & ~hazard & (state_q == ST_RUN);
        dec_ready = iss_valid & iss_ready;
        stall     = dec_valid & ~dec_ready;
    end

    assign is_ctrl  = (dec_opcode == OP_JAL) || (dec_opcode == OP_JALR) ||
                      (dec_opcode == OP_BRANCH);
    assign issue_wr = dec_ready && (dec_rd != 5'd0);
    assign wb_nz    = wb_valid && (wb_rd != 5'd0);
    assign wb_hit   = wb_nz && busy_q[wb_rd];
    assign wb_spur  = wb_nz && !busy_q[wb_rd];

    always_comb begin
        busy_d = busy_q;
        if (wb_hit) busy_d[wb_rd] = 1'b0;
        // Set after clear so an issue to the register being retired keeps it busy.
        if (issue_wr) busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (issue_wr && !wb_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue_wr && wb_hit) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        spur_d = spur_q | wb_spur;

        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (dec_ready && is_ctrl) state_d = ST_BRWAIT;
        end else begin
            if (br_done) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            busy_q  <= 32'b0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            spur_q  <= spur_d;
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = cnt_q;
    assign spur_wb  = spur_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized traffic
// compared against a register-set reference model.
module tb_issue_scoreboard;

    localparam int MAX_PEND = 4;
    localparam int CNT_W    = 3;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid;
    logic [6:0]       dec_opcode;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic             dec_ready, iss_valid, iss_ready;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             br_done, stall;
    logic [31:0]      busy;
    logic [CNT_W-1:0] pend_cnt;
    logic             spur_wb;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: set of registers with pending writes, branch-wait flag, sticky error.
    logic [31:0] m_busy;
    bit          m_wait;
    bit          m_spur;

    issue_scoreboard #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_ready(dec_ready),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .br_done(br_done), .stall(stall), .busy(busy), .pend_cnt(pend_cnt), .spur_wb(spur_wb)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt();
        return $countones(m_busy);
    endfunction

    function automatic bit still_pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit exp_iv();
        bit haz;
        haz = still_pending(dec_rs1) || still_pending(dec_rs2) ||
              ((dec_rd != 5'd0) && (still_pending(dec_rd) || m_cnt() == MAX_PEND));
        return dec_valid && !haz && !m_wait;
    endfunction

    function automatic bit exp_rdy();
        return exp_iv() && iss_ready;
    endfunction

    task automatic idle_inputs();
        dec_valid = 0; dec_opcode = OP_ALU; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
        iss_ready = 1; wb_valid = 0; wb_rd = 0; br_done = 0;
    endtask

    task automatic set_dec(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
        dec_valid = 1; dec_opcode = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    endtask

    // Advance one clock, applying the model's rules to the inputs held during the cycle.
    task automatic tick();
        logic [31:0] nb;
        bit          iss, nw, ns;
        iss = exp_rdy();
        nb  = m_busy;
        ns  = m_spur;
        nw  = m_wait;
        if (wb_valid && wb_rd != 5'd0) begin
            if (m_busy[wb_rd]) nb[wb_rd] = 1'b0;
            else ns = 1'b1;
        end
        if (iss && dec_rd != 5'd0) nb[dec_rd] = 1'b1;
        if (m_wait) begin
            if (br_done) nw = 0;
        end else if (iss && (dec_opcode == OP_BR || dec_opcode == OP_JAL ||
                             dec_opcode == OP_JALR)) begin
            nw = 1;
        end
        @(posedge clk);
        m_busy = nb; m_spur = ns; m_wait = nw;
        #1;
    endtask

    task automatic model_reset();
        m_busy = 32'b0; m_wait = 0; m_spur = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({dec_ready, iss_valid, stall, busy, pend_cnt, spur_wb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%h cnt=%0d iv=%b rdy=%b st=%b spur=%b, want all 0",
                     busy, pend_cnt, iss_valid, dec_ready, stall, spur_wb);
        end
        // Build up state, then assert reset asynchronously mid-cycle.
        set_dec(OP_ALU, 5'd3, 0, 0); tick();
        set_dec(OP_ALU, 5'd4, 0, 0); wb_valid = 1; wb_rd = 5'd11; tick();
        idle_inputs();
        n_checks++;
        if (pend_cnt !== 3'd2 || spur_wb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: got cnt=%0d spur=%b, want cnt=2 spur=1", pend_cnt, spur_wb);
        end
        #2 rst = 1;
        #1;
        model_reset();
        n_checks++;
        if (busy !== 32'b0 || pend_cnt !== '0 || iss_valid !== 1'b0 || spur_wb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%h cnt=%0d iv=%b spur=%b, want 0", busy, pend_cnt,
                     iss_valid, spur_wb);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_raw();
        idle_inputs();
        set_dec(OP_ALU, 5'd5, 5'd1, 5'd2); tick();
        set_dec(OP_ALU, 5'd6, 5'd5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1 || iss_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall[%0d]: got stall=%b iv=%b, want stall=1 iv=0", i, stall,
                         iss_valid);
            end
            tick();
        end
        wb_valid = 1; wb_rd = 5'd5; #1;
        n_checks++;
        if (iss_valid !== 1'b1 || dec_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_bypass: got iv=%b rdy=%b stall=%b, want 1 1 0", iss_valid, dec_ready,
                     stall);
        end
        tick(); idle_inputs();
        n_checks++;
        if (busy !== 32'h0000_0040 || pend_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL raw_after: got busy=%h cnt=%0d, want busy=00000040 cnt=1", busy, pend_cnt);
        end
    endtask

    task automatic test_waw_simul();
        do_reset();
        set_dec(OP_ALU, 5'd7, 0, 0); tick();
        set_dec(OP_ALU, 5'd7, 0, 0); wb_valid = 1; wb_rd = 5'd7; #1;
        n_checks++;
        if (iss_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_issue: got iv=%b, want 1", iss_valid);
        end
        tick(); idle_inputs();
        n_checks++;
        if (busy !== 32'h0000_0080 || pend_cnt !== 3'd1 || spur_wb !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_state: got busy=%h cnt=%0d spur=%b, want 00000080 1 0", busy, pend_cnt,
                     spur_wb);
        end
        // Different registers in the same cycle: both apply, count steady.
        set_dec(OP_ALU, 5'd8, 0, 0); wb_valid = 1; wb_rd = 5'd7; tick(); idle_inputs();
        n_checks++;
        if (busy !== 32'h0000_0100 || pend_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL simul_diff: got busy=%h cnt=%0d, want 00000100 1", busy, pend_cnt);
        end
    endtask

    task automatic test_capacity();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            set_dec(OP_ALU, 5'(r), 0, 0); tick();
        end
        set_dec(OP_ALU, 5'd6, 0, 0); #1;
        n_checks++;
        if (pend_cnt !== 3'd4 || iss_valid !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_full: got cnt=%0d iv=%b stall=%b, want 4 0 1", pend_cnt, iss_valid,
                     stall);
        end
        set_dec(OP_STORE, 5'd0, 5'd0, 5'd0); #1;
        n_checks++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_store: got rdy=%b, want 1", dec_ready);
        end
        tick();
        // Retire x1; the count drops at the edge, so rd=6 goes the following cycle.
        idle_inputs(); wb_valid = 1; wb_rd = 5'd1; tick(); idle_inputs();
        set_dec(OP_ALU, 5'd6, 0, 0); #1;
        n_checks++;
        if (pend_cnt !== 3'd3 || dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_resume: got cnt=%0d rdy=%b, want 3 1", pend_cnt, dec_ready);
        end
        tick(); idle_inputs();
        n_checks++;
        if (busy !== 32'h0000_005C || pend_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL cap_after: got busy=%h cnt=%0d, want 0000005c 4", busy, pend_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_dec(OP_BR, 5'd0, 5'd0, 5'd0); tick();
        set_dec(OP_ALU, 5'd9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (iss_valid !== 1'b0 || dec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL br_hold[%0d]: got iv=%b rdy=%b, want 0 0", i, iss_valid, dec_ready);
            end
            tick();
        end
        br_done = 1; tick(); br_done = 0; #1;
        n_checks++;
        if (iss_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL br_resume: got iv=%b, want 1", iss_valid);
        end
        tick(); idle_inputs();
    endtask

    task automatic test_spurious_backpressure();
        do_reset();
        wb_valid = 1; wb_rd = 5'd9; tick(); idle_inputs();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (spur_wb !== 1'b1 || pend_cnt !== '0 || busy !== 32'b0) begin
                n_fail++;
                $display("FAIL spur_hold[%0d]: got spur=%b cnt=%0d busy=%h, want 1 0 0", i, spur_wb,
                         pend_cnt, busy);
            end
            tick();
        end
        set_dec(OP_ALU, 5'd10, 0, 0); iss_ready = 0; #1;
        n_checks++;
        if (iss_valid !== 1'b1 || dec_ready !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got iv=%b rdy=%b stall=%b, want 1 0 1", iss_valid, dec_ready,
                     stall);
        end
        tick(); idle_inputs();
        n_checks++;
        if (busy !== 32'b0 || pend_cnt !== '0) begin
            n_fail++;
            $display("FAIL bp_state: got busy=%h cnt=%0d, want 0 0", busy, pend_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        ops[0] = OP_ALU; ops[1] = OP_STORE; ops[2] = OP_BR; ops[3] = OP_JAL; ops[4] = OP_JALR;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            dec_valid  = ($urandom_range(0, 9) < 8);
            dec_opcode = ($urandom_range(0, 9) < 7) ? OP_ALU : ops[$urandom_range(0, 4)];
            dec_rd     = 5'($urandom_range(0, 7));
            dec_rs1    = 5'($urandom_range(0, 7));
            dec_rs2    = 5'($urandom_range(0, 7));
            iss_ready  = ($urandom_range(0, 9) < 8);
            br_done    = ($urandom_range(0, 3) == 0);
            wb_valid   = ($urandom_range(0, 9) < 5);
            wb_rd      = 5'($urandom_range(0, 7));
            // Mostly retire a register that is really pending.
            if (m_busy != 32'b0 && $urandom_range(0, 9) < 8) begin
                while (!m_busy[wb_rd]) wb_rd = 5'($urandom_range(1, 7));
            end
            #1;
            n_checks++;
            if (iss_valid !== exp_iv() || dec_ready !== exp_rdy() ||
                stall !== (dec_valid && !exp_rdy())) begin
                n_fail++;
                $display("FAIL rnd_comb[%0d]: got iv=%b rdy=%b st=%b, want iv=%b rdy=%b", c,
                         iss_valid, dec_ready, stall, exp_iv(), exp_rdy());
            end
            tick();
            n_checks++;
            if (busy !== m_busy || pend_cnt !== CNT_W'(m_cnt()) || spur_wb !== m_spur) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got busy=%h cnt=%0d spur=%b, want %h %0d %b", c, busy,
                         pend_cnt, spur_wb, m_busy, m_cnt(), m_spur);
            end
            if (c % 150 == 149) do_reset();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_raw();
        test_waw_simul();
        test_capacity();
        test_branch();
        test_spurious_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
